// File: rtl/product_bcd_converter.sv
// product_bcd_converter: converts each new multiplier product to registered BCD
// digits using a sequential double-dabble, one shift-add-3 iteration per clock.
// Ports:
//   clk, reset     - clock; synchronous active-high reset
//   done, product  - multiplier completion flag and result (valid while done=1)
//   bcd_out        - registered BCD digits, ones digit in the low nibble
//   result_bin     - binary value matching the current bcd_out
//   bcd_valid      - one-cycle strobe in the cycle bcd_out/result_bin update
//   busy           - high while a conversion or publish is in progress
//   overrun        - sticky, set when a queued product was overwritten
module product_bcd_converter #(
   parameter int PRODUCT_WIDTH = 6,
   parameter int DIGITS        = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       done,
   input  logic [PRODUCT_WIDTH-1:0]   product,
   output logic [4*DIGITS-1:0]        bcd_out,
   output logic [PRODUCT_WIDTH-1:0]   result_bin,
   output logic                       bcd_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int SW = 4*DIGITS + PRODUCT_WIDTH;
   localparam int CW = $clog2(PRODUCT_WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(PRODUCT_WIDTH - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] PUBLISH = 2'd2;

   logic [1:0]               state;
   logic                     done_q;
   logic                     start_evt;
   logic [SW-1:0]            shift_q;
   logic [SW-1:0]            shift_adj;
   logic [SW-1:0]            shift_nxt;
   logic [CW-1:0]            iter;
   logic [PRODUCT_WIDTH-1:0] operand;
   logic [PRODUCT_WIDTH-1:0] pend_val;
   logic                     pend;

   // Only the rising edge of done counts, so a held done gives one event.
   assign start_evt = done & ~done_q;
   assign busy      = (state != IDLE);

   // One double-dabble step: add 3 to every BCD nibble >= 5 (no carry
   // between nibbles), then shift the whole {bcd, bin} register left.
   always_comb begin
      shift_adj = shift_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (shift_adj[PRODUCT_WIDTH + 4*d +: 4] >= 4'd5)
            shift_adj[PRODUCT_WIDTH + 4*d +: 4] = shift_adj[PRODUCT_WIDTH + 4*d +: 4] + 4'd3;
      end
      shift_nxt = shift_adj << 1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         done_q     <= 1'b0;
         shift_q    <= '0;
         iter       <= '0;
         operand    <= '0;
         pend_val   <= '0;
         pend       <= 1'b0;
         bcd_out    <= '0;
         result_bin <= '0;
         bcd_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done_q    <= done;
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_evt) begin
                  shift_q <= {{(4*DIGITS){1'b0}}, product};
                  operand <= product;
                  iter    <= '0;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               shift_q <= shift_nxt;
               iter    <= iter + 1'b1;
               if (iter == LAST_ITER)
                  state <= PUBLISH;
               // Single-entry queue; a second arrival overwrites it and is
               // flagged, newest product wins.
               if (start_evt) begin
                  pend_val <= product;
                  pend     <= 1'b1;
                  if (pend)
                     overrun <= 1'b1;
               end
            end
            PUBLISH: begin
               bcd_out    <= shift_q[SW-1:PRODUCT_WIDTH];
               result_bin <= operand;
               bcd_valid  <= 1'b1;
               iter       <= '0;
               if (pend) begin
                  // Queued value is consumed now, so a same-cycle event
                  // simply refills the queue without an overrun.
                  shift_q <= {{(4*DIGITS){1'b0}}, pend_val};
                  operand <= pend_val;
                  state   <= CONVERT;
                  if (start_evt)
                     pend_val <= product;
                  else
                     pend <= 1'b0;
               end else if (start_evt) begin
                  shift_q <= {{(4*DIGITS){1'b0}}, product};
                  operand <= product;
                  state   <= CONVERT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       done = 1'b0;
   logic [5:0] product = '0;
   logic [7:0] bcd_out;
   logic [5:0] result_bin;
   logic       bcd_valid;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   product_bcd_converter #(.PRODUCT_WIDTH(6), .DIGITS(2)) dut (
      .clk(clk), .reset(reset), .done(done), .product(product),
      .bcd_out(bcd_out), .result_bin(result_bin), .bcd_valid(bcd_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] bcd;
      logic [5:0] bin;
   } ev_t;

   ev_t evq[$];
   int  cyc = 0;
   int  busy_cnt = 0;

   // Edge counter plus a recorder of strobes and busy cycles, sampled 2ns after each edge.
   always @(posedge clk) begin
      ev_t e;
      cyc = cyc + 1;
      #2;
      if (bcd_valid) begin
         e.cyc = cyc;
         e.bcd = bcd_out;
         e.bin = result_bin;
         evq.push_back(e);
      end
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_ev(input string name, input int idx, input int cap, input int off,
                         input logic [7:0] bcd, input logic [5:0] bin);
      if (idx < evq.size()) begin
         chk({name, " strobe offset"}, evq[idx].cyc - cap, off);
         chk({name, " bcd_out"}, int'(evq[idx].bcd), int'(bcd));
         chk({name, " result_bin"}, int'(evq[idx].bin), int'(bin));
      end else begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: strobe %0d missing, got %0d strobes", name, idx, evq.size());
      end
   endtask

   // Raise done with a product for one cycle; returns the capture edge number.
   task automatic pulse(input logic [5:0] p, output int cap);
      done = 1'b1;
      product = p;
      step();
      cap = cyc;
      done = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, " bcd_out"}, int'(bcd_out), 0);
      chk({name, " result_bin"}, int'(result_bin), 0);
      chk({name, " bcd_valid"}, int'(bcd_valid), 0);
      chk({name, " busy"}, int'(busy), 0);
      chk({name, " overrun"}, int'(overrun), 0);
   endtask

   typedef struct {
      logic [5:0] prod;
      logic [7:0] exp_bcd;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int cap;
      int cap2;

      vecs[0] = '{6'd35, 8'h35};
      vecs[1] = '{6'd4,  8'h04};
      vecs[2] = '{6'd28, 8'h28};
      vecs[3] = '{6'd63, 8'h63};
      vecs[4] = '{6'd0,  8'h00};
      vecs[5] = '{6'd9,  8'h09};
      vecs[6] = '{6'd10, 8'h10};
      vecs[7] = '{6'd59, 8'h59};
      vecs[8] = '{6'd1,  8'h01};

      // Reset state
      reset = 1'b1;
      step(2);
      chk_zero("reset");
      reset = 1'b0;
      step(2);

      // done held high for 3 cycles produces a single conversion
      evq.delete();
      busy_cnt = 0;
      done = 1'b1;
      product = 6'd49;
      step();
      cap = cyc;
      step(2);
      done = 1'b0;
      step(12);
      chk("held count", evq.size(), 1);
      chk_ev("held", 0, cap, 7, 8'h49, 6'd49);
      chk("held busy cycles", busy_cnt, 7);
      chk("held overrun", int'(overrun), 0);

      // Isolated products with idle gaps
      for (int i = 0; i < 9; i++) begin
         evq.delete();
         busy_cnt = 0;
         pulse(vecs[i].prod, cap);
         step(12);
         chk($sformatf("vec%0d count", i), evq.size(), 1);
         chk_ev($sformatf("vec%0d", i), 0, cap, 7, vecs[i].exp_bcd, vecs[i].prod);
         chk($sformatf("vec%0d busy cycles", i), busy_cnt, 7);
         chk($sformatf("vec%0d overrun", i), int'(overrun), 0);
         chk($sformatf("vec%0d hold bcd_out", i), int'(bcd_out), int'(vecs[i].exp_bcd));
      end

      // Second edge 3 cycles after the first is queued and published at +14
      evq.delete();
      busy_cnt = 0;
      pulse(6'd49, cap);
      step(2);
      pulse(6'd35, cap2);
      step(14);
      chk("queue count", evq.size(), 2);
      chk("queue second edge", cap2 - cap, 3);
      chk_ev("queue first", 0, cap, 7, 8'h49, 6'd49);
      chk_ev("queue second", 1, cap, 14, 8'h35, 6'd35);
      chk("queue busy cycles", busy_cnt, 14);
      chk("queue overrun", int'(overrun), 0);

      // Edge coinciding with PUBLISH, queue empty: back-to-back, no IDLE cycle
      evq.delete();
      busy_cnt = 0;
      pulse(6'd49, cap);
      step(6);
      pulse(6'd28, cap2);
      step(12);
      chk("b2b edge offset", cap2 - cap, 7);
      chk("b2b count", evq.size(), 2);
      chk_ev("b2b first", 0, cap, 7, 8'h49, 6'd49);
      chk_ev("b2b second", 1, cap, 14, 8'h28, 6'd28);
      chk("b2b busy cycles", busy_cnt, 14);
      chk("b2b overrun", int'(overrun), 0);

      // Reset during iteration 3 abandons the conversion
      evq.delete();
      pulse(6'd49, cap);
      step(3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_zero("midreset");
      step(10);
      chk("midreset strobes", evq.size(), 0);
      evq.delete();
      busy_cnt = 0;
      pulse(6'd28, cap);
      step(12);
      chk("after reset count", evq.size(), 1);
      chk_ev("after reset", 0, cap, 7, 8'h28, 6'd28);
      chk("after reset busy cycles", busy_cnt, 7);

      // Three edges in one conversion: middle one dropped, overrun sticky
      evq.delete();
      pulse(6'd49, cap);
      step();
      pulse(6'd35, cap2);
      step();
      pulse(6'd4, cap2);
      chk("ovr third edge", cap2 - cap, 4);
      chk("ovr flag early", int'(overrun), 1);
      step(20);
      chk("ovr count", evq.size(), 2);
      chk_ev("ovr first", 0, cap, 7, 8'h49, 6'd49);
      chk_ev("ovr second", 1, cap, 14, 8'h04, 6'd4);
      chk("ovr sticky", int'(overrun), 1);
      chk("ovr idle", int'(busy), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_zero("ovr reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
